morse_symbol_classifier: RTL and testbench

Timing front end of the Morse decoder. Consumes the debounced key level `b` and converts press and gap durations into single-cycle `dot`, `dash`, `LG` (letter gap) and `WG` (word gap) pulses. These pulses drive the downstream symbol shift register, symbol counter and ROM/UART write logic. Durations are measured in "units" of `FINAL_VALUE` clock cycles.

---
 rtl/morse_symbol_classifier.sv | 147 ++++++++++++++
 tb/tb_morse_symbol_classifier.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/morse_symbol_classifier.sv
// morse_symbol_classifier
// Timing front end of the Morse decoder. Measures key-down and key-up
// durations in units of FINAL_VALUE clock cycles and emits one-cycle pulses
// for a completed dot or dash press, a letter gap and a word gap.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   b        in   debounced key level (1 = pressed), synchronous to clk
//   dot      out  one-cycle pulse: dot press completed
//   dash     out  one-cycle pulse: dash press completed
//   LG       out  one-cycle pulse: letter gap reached
//   WG       out  one-cycle pulse: word gap reached
module morse_symbol_classifier #(
  parameter int unsigned FINAL_VALUE = 5_000_000,
  parameter int unsigned DASH_UNITS  = 2,
  parameter int unsigned LG_UNITS    = 3,
  parameter int unsigned WG_UNITS    = 7
) (
  input  logic clk,
  input  logic reset_n,
  input  logic b,
  output logic dot,
  output logic dash,
  output logic LG,
  output logic WG
);

  localparam int unsigned   TW     = (FINAL_VALUE > 1) ? $clog2(FINAL_VALUE) : 1;
  localparam logic [TW-1:0] TMAX   = TW'(FINAL_VALUE - 1);
  localparam logic [2:0]    DASH_U = 3'(DASH_UNITS);
  localparam logic [2:0]    LG_U   = 3'(LG_UNITS);
  localparam logic [2:0]    WG_U   = 3'(WG_UNITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_GAP,
    S_LGAP
  } state_t;

  state_t        r_state;
  state_t        w_state_n;
  logic          r_b_q;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_units;
  logic          r_dot, r_dash, r_lg, r_wg;
  logic          w_dot, w_dash, w_lg, w_wg;
  logic          w_rise, w_fall, w_edge, w_tick;

  assign w_rise = b & ~r_b_q;
  assign w_fall = ~b & r_b_q;
  assign w_edge = w_rise | w_fall;
  assign w_tick = ~w_edge && (r_timer == TMAX);

  // b_q resets high so a key already held when reset releases is not
  // mistaken for a fresh press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_b_q <= 1'b1;
    end else begin
      r_b_q <= b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (w_edge || w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Saturating unit counter: long presses/gaps hold at 7 instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_units <= '0;
    end else if (w_edge) begin
      r_units <= '0;
    end else if (w_tick && (r_units != 3'd7)) begin
      r_units <= r_units + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_dot   <= 1'b0;
      r_dash  <= 1'b0;
      r_lg    <= 1'b0;
      r_wg    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_dot   <= w_dot;
      r_dash  <= w_dash;
      r_lg    <= w_lg;
      r_wg    <= w_wg;
    end
  end

  // A rise is checked before the gap thresholds so that a press starting on
  // the threshold cycle continues the letter without a gap pulse.
  always_comb begin
    w_state_n = r_state;
    w_dot     = 1'b0;
    w_dash    = 1'b0;
    w_lg      = 1'b0;
    w_wg      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) w_state_n = S_PRESS;
      end
      S_PRESS: begin
        if (w_fall) begin
          w_state_n = S_GAP;
          if (r_units >= DASH_U) w_dash = 1'b1;
          else                   w_dot  = 1'b1;
        end
      end
      S_GAP: begin
        if (w_rise) begin
          w_state_n = S_PRESS;
        end else if (r_units == LG_U) begin
          w_lg      = 1'b1;
          w_state_n = S_LGAP;
        end
      end
      S_LGAP: begin
        if (w_rise) begin
          w_state_n = S_PRESS;
        end else if (r_units == WG_U) begin
          w_wg      = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign dot  = r_dot;
  assign dash = r_dash;
  assign LG   = r_lg;
  assign WG   = r_wg;

endmodule

// File: tb/tb_morse_symbol_classifier.sv
// Directed bench for morse_symbol_classifier with FINAL_VALUE = 10.
// Pulses are logged with their cycle stamp; each scenario compares the pulse
// sequence and the latency from the relevant key release.
module tb_morse_symbol_classifier;

  localparam int K_DOT  = 1;
  localparam int K_DASH = 2;
  localparam int K_LG   = 3;
  localparam int K_WG   = 4;

  logic clk;
  logic reset_n;
  logic b;
  logic dot, dash, LG, WG;

  typedef struct {
    int kind;
    int t;
  } ev_t;

  ev_t ev[$];
  int  cyc;
  int  n_chk;
  int  n_fail;
  int  n_hot;
  int  t_rel;
  int  t_rel2;
  int  n_dot;

  morse_symbol_classifier #(
    .FINAL_VALUE(10),
    .DASH_UNITS (2),
    .LG_UNITS   (3),
    .WG_UNITS   (7)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .b      (b),
    .dot    (dot),
    .dash   (dash),
    .LG     (LG),
    .WG     (WG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ($countones({dot, dash, LG, WG}) > 1) n_hot++;
    if (dot)  ev.push_back('{K_DOT,  cyc});
    if (dash) ev.push_back('{K_DASH, cyc});
    if (LG)   ev.push_back('{K_LG,   cyc});
    if (WG)   ev.push_back('{K_WG,   cyc});
  end

  always @(negedge clk) begin
    assert ($onehot0({dot, dash, LG, WG}))
      else $error("FAIL onehot: outputs=%b", {dot, dash, LG, WG});
  end

  task automatic check_val(input string tag, input int obs, input int exp, input int tol);
    n_chk++;
    if ((obs > exp + tol) || (obs < exp - tol)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int ev_kind(input int i);
    if (i < ev.size()) return ev[i].kind;
    return -1;
  endfunction

  function automatic int ev_off(input int i, input int ref_t);
    if (i < ev.size()) return ev[i].t - ref_t;
    return -1000;
  endfunction

  // Drive b to lvl at the current falling edge and hold it for n cycles.
  task automatic hold(input logic lvl, input int n);
    b = lvl;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    n_hot   = 0;
    b       = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_dot",  int'(dot),  0, 0);
    check_val("rst_dash", int'(dash), 0, 0);
    check_val("rst_lg",   int'(LG),   0, 0);
    check_val("rst_wg",   int'(WG),   0, 0);
    reset_n = 1'b1;
    hold(1'b0, 5);
    check_val("idle_quiet", ev.size(), 0, 0);

    // Dot followed by a full gap
    ev.delete();
    hold(1'b1, 8);
    t_rel = cyc;
    hold(1'b0, 90);
    check_val("dot_count", ev.size(), 3, 0);
    check_val("dot_k0",    ev_kind(0), K_DOT, 0);
    check_val("dot_lat",   ev_off(0, t_rel), 2, 2);
    check_val("dot_k1",    ev_kind(1), K_LG, 0);
    check_val("lg_lat",    ev_off(1, t_rel), 30, 2);
    check_val("dot_k2",    ev_kind(2), K_WG, 0);
    check_val("wg_lat",    ev_off(2, t_rel), 70, 2);

    // Dash of 35 cycles
    ev.delete();
    hold(1'b1, 35);
    t_rel = cyc;
    hold(1'b0, 90);
    check_val("dash_count", ev.size(), 3, 0);
    check_val("dash_k0",    ev_kind(0), K_DASH, 0);
    check_val("dash_lat",   ev_off(0, t_rel), 2, 2);

    // Very long press saturates the unit counter and is still one dash
    ev.delete();
    hold(1'b1, 200);
    hold(1'b0, 90);
    check_val("sat_count", ev.size(), 3, 0);
    check_val("sat_k0",    ev_kind(0), K_DASH, 0);
    check_val("sat_k1",    ev_kind(1), K_LG, 0);

    // Intra-letter gaps: dot, dash, dot with no gap pulses between
    ev.delete();
    hold(1'b1, 8);
    hold(1'b0, 15);
    hold(1'b1, 35);
    hold(1'b0, 15);
    hold(1'b1, 8);
    hold(1'b0, 90);
    check_val("intra_count", ev.size(), 5, 0);
    check_val("intra_k0",    ev_kind(0), K_DOT, 0);
    check_val("intra_k1",    ev_kind(1), K_DASH, 0);
    check_val("intra_k2",    ev_kind(2), K_DOT, 0);
    check_val("intra_k3",    ev_kind(3), K_LG, 0);
    check_val("intra_k4",    ev_kind(4), K_WG, 0);

    // Letter gap then word gap, then long idle
    ev.delete();
    hold(1'b1, 8);
    t_rel = cyc;
    hold(1'b0, 45);
    hold(1'b1, 8);
    t_rel2 = cyc;
    hold(1'b0, 300);
    check_val("lw_count", ev.size(), 5, 0);
    check_val("lw_k0",    ev_kind(0), K_DOT, 0);
    check_val("lw_k1",    ev_kind(1), K_LG, 0);
    check_val("lw_lg1",   ev_off(1, t_rel), 30, 2);
    check_val("lw_k2",    ev_kind(2), K_DOT, 0);
    check_val("lw_k3",    ev_kind(3), K_LG, 0);
    check_val("lw_k4",    ev_kind(4), K_WG, 0);
    check_val("lw_wg",    ev_off(4, t_rel2), 70, 2);

    // Reset in the middle of a press discards it; key still held afterwards
    ev.delete();
    hold(1'b1, 10);
    reset_n = 1'b0;
    @(negedge clk);
    check_val("midrst_dot", int'(dot), 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    hold(1'b1, 40);
    hold(1'b0, 90);
    check_val("rst_silent", ev.size(), 0, 0);
    ev.delete();
    hold(1'b1, 8);
    hold(1'b0, 90);
    n_dot = 0;
    foreach (ev[i]) if (ev[i].kind == K_DOT) n_dot++;
    check_val("rst_fresh_dots", n_dot, 1, 0);
    check_val("rst_fresh_k0",   ev_kind(0), K_DOT, 0);

    // Rise landing on the letter-gap threshold suppresses LG
    for (int g = 30; g <= 31; g++) begin
      ev.delete();
      hold(1'b1, 8);
      hold(1'b0, g);
      hold(1'b1, 8);
      hold(1'b0, 90);
      check_val($sformatf("race%0d_count", g), ev.size(), 4, 0);
      check_val($sformatf("race%0d_k0", g),    ev_kind(0), K_DOT, 0);
      check_val($sformatf("race%0d_k1", g),    ev_kind(1), K_DOT, 0);
      check_val($sformatf("race%0d_k2", g),    ev_kind(2), K_LG, 0);
    end

    check_val("onehot_viol", n_hot, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
